// File: rtl/param_updown_counter_pkg.sv
// Shared constants for the parameterised up/down counter.
package param_updown_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 8;
  localparam int unsigned DEFAULT_PRESC_W = 4;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/param_updown_counter_prescaler.sv
// Enabled-cycle prescaler: pulses tick once every presc+1 running cycles.
module cnt_prescaler #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] cnt_nxt;

  // Tick on the terminal phase; only meaningful while globally enabled and running.
  assign tick = ena && run && (cnt == presc);

  // Next phase: cleared when not running or after the terminal phase.
  always_comb begin
    cnt_nxt = cnt;
    if (!run) begin
      cnt_nxt = '0;
    end else if (cnt == presc) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + PRESC_W'(1);
    end
  end

  // Phase register; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with inclusive limit, wrap/saturate boundary modes,
// prescaled ticks, terminal-count pulse and sticky boundary flag.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               en,
  input  logic               up,
  input  logic               mode,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr_flag,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               ovf_sticky,
  output logic               at_zero,
  output logic               at_limit
);

  logic             run;
  logic             tick;
  logic             evt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;

  // A load restarts the prescaler phase just like dropping en.
  assign run = en & ~load;

  cnt_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .run   (run),
    .presc (presc),
    .tick  (tick)
  );

  // Next count and boundary-event detection; load outranks tick.
  always_comb begin
    count_nxt = count;
    evt       = 1'b0;
    if (load) begin
      count_nxt = (load_val > limit) ? limit : load_val;
    end else if (tick) begin
      if (up) begin
        if (count < limit) begin
          count_nxt = count + WIDTH'(1);
        end else begin
          evt       = 1'b1;
          count_nxt = (mode == MODE_SAT) ? limit : '0;
        end
      end else begin
        if (count == '0) begin
          evt       = 1'b1;
          count_nxt = (mode == MODE_SAT) ? '0 : limit;
        end else if (count > limit) begin
          count_nxt = limit;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
    tc_nxt  = evt;
    ovf_nxt = evt | (ovf_sticky & ~clr_flag);
  end

  // Output registers; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (ena) begin
      count      <= count_nxt;
      tc         <= tc_nxt;
      ovf_sticky <= ovf_nxt;
    end
  end

  // Status decodes of the registered count.
  assign at_zero  = (count == '0);
  assign at_limit = (count >= limit);

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_param_updown_counter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned PRESC_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ena;
  logic               en;
  logic               up;
  logic               mode;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc;
  logic               clr_flag;
  logic [WIDTH-1:0]   count;
  logic               tc;
  logic               ovf_sticky;
  logic               at_zero;
  logic               at_limit;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  // Behavioural model state
  int m_count = 0;
  int m_pre   = 0;
  int m_tc    = 0;
  int m_ovf   = 0;

  param_updown_counter #(
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .en         (en),
    .up         (up),
    .mode       (mode),
    .load       (load),
    .load_val   (load_val),
    .limit      (limit),
    .presc      (presc),
    .clr_flag   (clr_flag),
    .count      (count),
    .tc         (tc),
    .ovf_sticky (ovf_sticky),
    .at_zero    (at_zero),
    .at_limit   (at_limit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string name, input int c, input int t, input int o);
    chk({name, ".count"}, int'(count), c);
    chk({name, ".tc"}, int'(tc), t);
    chk({name, ".ovf"}, int'(ovf_sticky), o);
  endtask

  // Reference model: the counter's rules written directly as arithmetic.
  always @(posedge clk or negedge rst_n) begin
    int lim;
    bit tick;
    bit evt;
    if (!rst_n) begin
      m_count = 0;
      m_pre   = 0;
      m_tc    = 0;
      m_ovf   = 0;
    end else if (ena) begin
      lim  = int'(limit);
      evt  = 1'b0;
      tick = en && !load && (m_pre == int'(presc));
      if (!en || load || tick) m_pre = 0;
      else m_pre = m_pre + 1;
      if (load) begin
        m_count = (int'(load_val) < lim) ? int'(load_val) : lim;
      end else if (tick) begin
        if (up) begin
          if (m_count < lim) m_count = m_count + 1;
          else begin
            evt = 1'b1;
            m_count = mode ? lim : 0;
          end
        end else begin
          if (m_count == 0) begin
            evt = 1'b1;
            m_count = mode ? 0 : lim;
          end else if (m_count > lim) m_count = lim;
          else m_count = m_count - 1;
        end
      end
      m_tc = evt ? 1 : 0;
      if (evt) m_ovf = 1;
      else if (clr_flag) m_ovf = 0;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model.count", int'(count), m_count);
      chk("model.tc", int'(tc), m_tc);
      chk("model.ovf", int'(ovf_sticky), m_ovf);
      chk("model.at_zero", int'(at_zero), (m_count == 0) ? 1 : 0);
      chk("model.at_limit", int'(at_limit), (m_count >= int'(limit)) ? 1 : 0);
    end
  end

  initial begin
    int tcs;
    rst_n    = 1'b0;
    ena      = 1'b1;
    en       = 1'b0;
    up       = 1'b1;
    mode     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    limit    = 8'd255;
    presc    = '0;
    clr_flag = 1'b0;
    step(2);
    expect3("reset", 0, 0, 0);

    // Free-running wrap over the full range
    rst_n  = 1'b1;
    en     = 1'b1;
    chk_on = 1'b1;
    tcs    = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (tc) tcs++;
      if (i == 254) expect3("wrap.top", 255, 0, 0);
      if (i == 255) expect3("wrap.edge", 0, 1, 1);
    end
    chk("wrap.tc_pulses", tcs, 1);
    expect3("wrap.end", 44, 0, 1);

    // Saturate at limit 9, then count down and hold at 0
    load = 1'b1; load_val = 8'd0; limit = 8'd9; mode = 1'b1;
    step(1);
    load = 1'b0;
    step(9);  expect3("sat.reach", 9, 0, 1);
    step(1);  expect3("sat.hold1", 9, 1, 1);
    step(1);  expect3("sat.hold2", 9, 1, 1);
    up = 1'b0;
    step(9);  expect3("sat.down", 0, 0, 1);
    step(1);  expect3("sat.zero", 0, 1, 1);

    // Prescaler of 4 and restart after en drops
    load = 1'b1; load_val = 8'd0; mode = 1'b0; up = 1'b1; limit = 8'd255; presc = 4'd3;
    step(1);
    load = 1'b0;
    step(3);  chk("presc.pre", int'(count), 0);
    step(1);  chk("presc.first", int'(count), 1);
    en = 1'b0;
    step(2);  chk("presc.paused", int'(count), 1);
    en = 1'b1;
    step(3);  chk("presc.restart_wait", int'(count), 1);
    step(1);  chk("presc.restart", int'(count), 2);

    // Load clamps to limit and beats a simultaneous tick
    en = 1'b0; clr_flag = 1'b1;
    step(1);  chk("clr.alone", int'(ovf_sticky), 0);
    clr_flag = 1'b0; load = 1'b1; load_val = 8'd200; limit = 8'd100;
    step(1);  expect3("load.clamp", 100, 0, 0);
    chk("load.at_limit", int'(at_limit), 1);
    chk("load.at_zero", int'(at_zero), 0);
    load_val = 8'd50; en = 1'b1; presc = 4'd0;
    step(1);  expect3("load.wins", 50, 0, 0);

    // Down wrap at zero and clear-vs-set priority
    load_val = 8'd0; limit = 8'd5; up = 1'b0;
    step(1);  chk("dn.load", int'(count), 0);
    load = 1'b0;
    step(1);  expect3("dn.wrap", 5, 1, 1);
    step(5);  expect3("dn.zero", 0, 0, 1);
    clr_flag = 1'b1;
    step(1);  expect3("dn.set_beats_clr", 5, 1, 1);
    en = 1'b0;
    step(1);  expect3("dn.clr", 5, 0, 0);
    clr_flag = 1'b0;

    // Limit of zero: every tick is a boundary event
    load = 1'b1; load_val = 8'd7; limit = 8'd0; en = 1'b1; up = 1'b1;
    step(1);  expect3("lim0.load", 0, 0, 0);
    load = 1'b0;
    step(1);  expect3("lim0.up", 0, 1, 1);
    up = 1'b0;
    step(1);  expect3("lim0.dn", 0, 1, 1);

    // Asynchronous reset mid prescaler phase, then freeze with ena low
    up = 1'b1; limit = 8'd255; presc = 4'd7; load = 1'b1; load_val = 8'd3;
    step(1);
    load = 1'b0;
    step(5);  chk("rst.pre", int'(count), 3);
    rst_n = 1'b0;
    #1;       expect3("rst.async", 0, 0, 0);
    step(1);
    rst_n = 1'b1; presc = 4'd2; limit = 8'd1; mode = 1'b0;
    step(3);  chk("rst.fresh_phase", int'(count), 1);
    step(3);  expect3("frz.pre", 0, 1, 1);
    ena = 1'b0;
    step(10); expect3("frz.tc_held", 0, 1, 1);
    ena = 1'b1;
    step(1);  expect3("frz.phase1", 0, 0, 1);
    ena = 1'b0;
    step(10); chk("frz.count", int'(count), 0);
    ena = 1'b1;
    step(1);  chk("frz.phase2", int'(count), 0);
    step(1);  chk("frz.tick", int'(count), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ena      = ($urandom_range(0, 9) != 0);
      en       = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      load     = ($urandom_range(0, 19) == 0);
      load_val = WIDTH'($urandom);
      if ($urandom_range(0, 49) == 0)
        limit = ($urandom_range(0, 1) != 0) ? WIDTH'($urandom_range(0, 12)) : WIDTH'($urandom);
      if (ena && !en && $urandom_range(0, 2) == 0) presc = PRESC_W'($urandom_range(0, 3));
      clr_flag = ($urandom_range(0, 9) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      step(1);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (2..16).
REQ-002 SHALL have parameter PRESC_W, default 4, prescaler divide-select width.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ena  input  1  global enable; when low, all state holds.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 = up, 0 = down.
REQ-008 SHALL have port mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  value for load.
REQ-011 SHALL have port limit  input  WIDTH  inclusive upper count bound.
REQ-012 SHALL have port presc  input  PRESC_W  tick every presc+1 enabled cycles.
REQ-013 SHALL have port clr_flag  input  1  clears ovf_sticky.
REQ-014 SHALL have port count  output  WIDTH  registered count value.
REQ-015 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-016 SHALL have port ovf_sticky  output  1  sticky boundary-event flag.
REQ-017 SHALL have ports at_zero, at_limit  output  1 each  combinational decodes: count==0 and count>=limit.

Function
REQ-018 All state SHALL update only on rising clk with ena=1; with ena=0 all registers hold and tc holds its last value.
REQ-019 Prescaler SHALL count enabled cycles; a tick occurs on the cycle prescaler==presc, after which it returns to 0; presc=0 gives a tick every cycle.
REQ-020 Prescaler SHALL clear to 0 when en=0 or load=1, so the first tick after en rises comes presc+1 cycles later.
REQ-021 Priority per cycle SHALL be load > tick > hold.
REQ-022 Load SHALL set count to min(load_val, limit) on the next edge, with no tc pulse and no flag change.
REQ-023 Up tick with count<limit SHALL increment count by 1.
REQ-024 Up tick with count>=limit SHALL be a boundary event: wrap mode sets count=0; saturate mode sets count=limit.
REQ-025 Down tick with count>0 and count<=limit SHALL decrement count by 1; with count>limit it SHALL set count=limit (no event).
REQ-026 Down tick with count==0 SHALL be a boundary event: wrap mode sets count=limit; saturate mode holds 0.
REQ-027 tc SHALL be high for exactly the one cycle following each boundary event, and low otherwise (with ena=1).
REQ-028 ovf_sticky SHALL set on any boundary event and clear on clr_flag; simultaneous set and clear SHALL leave it set.
REQ-029 limit=0 SHALL hold count at 0 and make every tick a boundary event.
REQ-030 Changes to mode, up or limit SHALL take effect on the next tick with no glitch on registered outputs.

Reset
REQ-031 rst_n low SHALL asynchronously force count=0, prescaler=0, tc=0, ovf_sticky=0.
REQ-032 Reset release SHALL be synchronous to clk; counting resumes no earlier than the first edge with rst_n high.
REQ-033 Reset mid-count SHALL discard any in-progress prescaler phase.

Structure
REQ-034 A shared package SHALL hold MODE_WRAP=0, MODE_SAT=1, and the default WIDTH and PRESC_W constants.
REQ-035 The prescaler SHALL be a sub-module named cnt_prescaler (inputs clk, rst_n, ena, run, presc; output tick).
REQ-036 No combinational path SHALL exist from any input to count, tc or ovf_sticky.

Verification (WIDTH=8, PRESC_W=4)
REQ-037 Reset, en=1, up=1, presc=0, limit=255, mode=0, 300 cycles -> count 0..255, wraps to 0, tc pulses once at the wrap, ovf_sticky=1.
REQ-038 limit=9, mode=1, up=1, presc=0 from 0 -> count saturates at 9; tc pulses on each tick held at 9; up=0 then counts 9..0 and holds 0.
REQ-039 presc=3, en=1, up=1 from 0 -> count increments every 4 cycles; drop en for 2 cycles -> next increment 4 cycles after en returns.
REQ-040 load=1, load_val=200, limit=100 -> count=100; load together with a tick -> load wins, tc=0.
REQ-041 Down, wrap, limit=5, count=0 -> count=5 and tc pulse; clr_flag asserted in the same cycle as an event -> ovf_sticky stays 1; clr_flag alone -> 0.
REQ-042 rst_n pulsed low mid-count with presc=7 -> outputs zero immediately; ena=0 for 10 cycles -> count, tc and prescaler frozen.
